// File: rtl/pingpong_row_buffer.sv
// Double-buffered row store: renderer fills the back bank, display reads the front bank.
// Banks exchange roles on an accepted swap; the new back bank is optionally cleared first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | walking the back bank, writing the background word; no writes
// ST_FILL  | back bank accepts renderer writes
// ST_DONE  | row finished, back bank frozen until the display swaps
module pingpong_row_buffer #(
    parameter int                    PIXEL_BITS   = 4,
    parameter int                    PIX_PER_WORD = 4,
    parameter int                    WORDS        = 256,
    parameter int                    ADDR_BITS    = 8,
    parameter bit                    CLEAR_EN     = 1'b1,
    parameter logic [PIXEL_BITS-1:0] CLEAR_PIXEL  = '0
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               wr_en,
    input  logic [ADDR_BITS-1:0]               wr_addr,
    input  logic [PIX_PER_WORD-1:0]            wr_pix_en,
    input  logic [PIXEL_BITS*PIX_PER_WORD-1:0] wr_data,
    output logic                               wr_ready,
    input  logic                               row_done,
    input  logic                               swap,
    input  logic [ADDR_BITS-1:0]               rd_addr,
    output logic [PIXEL_BITS*PIX_PER_WORD-1:0] rd_data,
    output logic                               front_valid,
    output logic                               underrun,
    output logic                               overrun
);

    localparam int DW = PIXEL_BITS * PIX_PER_WORD;
    localparam logic [DW-1:0]        CLEAR_WORD = {PIX_PER_WORD{CLEAR_PIXEL}};
    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(WORDS - 1);
    localparam logic [ADDR_BITS:0]   WORDS_EXT  = (ADDR_BITS + 1)'(WORDS);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_FILL  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam state_t START_STATE = CLEAR_EN ? ST_CLEAR : ST_FILL;

    state_t state, state_nxt;

    logic                    bank_sel;
    logic [ADDR_BITS-1:0]    clr_cnt;
    logic                    clr_last;
    logic                    swap_ok;
    logic                    wr_addr_ok;
    logic                    rd_addr_ok;

    logic                    mem_we;
    logic [ADDR_BITS-1:0]    mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic [PIX_PER_WORD-1:0] mem_pix_en;

    logic [DW-1:0] mem0 [WORDS];
    logic [DW-1:0] mem1 [WORDS];

    assign clr_last   = (clr_cnt == LAST_ADDR);
    assign wr_addr_ok = ({1'b0, wr_addr} < WORDS_EXT);
    assign rd_addr_ok = ({1'b0, rd_addr} < WORDS_EXT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= START_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        swap_ok   = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clr_last) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                wr_ready = 1'b1;
                if (row_done) begin
                    state_nxt = ST_DONE;
                    swap_ok   = swap;
                end
            end
            ST_DONE: begin
                swap_ok = swap;
            end
            default: begin
                state_nxt = START_STATE;
            end
        endcase
        if (swap_ok) begin
            state_nxt = CLEAR_EN ? ST_CLEAR : ST_FILL;
        end
    end

    // The clear walker owns the back-bank write port while in ST_CLEAR.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
        mem_pix_en = wr_pix_en;
        if (state == ST_CLEAR) begin
            mem_we     = 1'b1;
            mem_addr   = clr_cnt;
            mem_wdata  = CLEAR_WORD;
            mem_pix_en = '1;
        end else if (wr_en && wr_ready && wr_addr_ok) begin
            mem_we = 1'b1;
        end
    end

    // Back bank is the one not selected by bank_sel.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < PIX_PER_WORD; i++) begin
                if (mem_pix_en[i]) begin
                    if (bank_sel) begin
                        mem0[mem_addr][i*PIXEL_BITS +: PIXEL_BITS] <= mem_wdata[i*PIXEL_BITS +: PIXEL_BITS];
                    end else begin
                        mem1[mem_addr][i*PIXEL_BITS +: PIXEL_BITS] <= mem_wdata[i*PIXEL_BITS +: PIXEL_BITS];
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bank_sel    <= 1'b0;
            front_valid <= 1'b0;
            rd_data     <= '0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            clr_cnt     <= '0;
        end else begin
            if (swap_ok) begin
                bank_sel    <= ~bank_sel;
                front_valid <= 1'b1;
            end
            if (state == ST_CLEAR && !clr_last) begin
                clr_cnt <= clr_cnt + ADDR_BITS'(1);
            end else begin
                clr_cnt <= '0;
            end
            underrun <= swap & ~swap_ok;
            overrun  <= wr_en & ~wr_ready & wr_addr_ok;
            if (rd_addr_ok) begin
                rd_data <= bank_sel ? mem1[rd_addr] : mem0[rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule
